// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with two write-back ports and a pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle write-back data (and clear busy) on reads.
module regfile_mp_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRP  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRP*AW-1:0]   rd_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_busy,
  input  logic                wb0_en,
  input  logic [AW-1:0]       wb0_addr,
  input  logic [XLEN-1:0]     wb0_data,
  input  logic                wb1_en,
  input  logic [AW-1:0]       wb1_addr,
  input  logic [XLEN-1:0]     wb1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     cnt_d;
  logic            wb0_hit;
  logic            wb1_hit;
  logic            iss_hit;

  assign wb0_hit = wb0_en && (wb0_addr != '0);
  assign wb1_hit = wb1_en && (wb1_addr != '0);
  assign iss_hit = iss_en && (iss_addr != '0);

  // Issue beats write-back so a new producer keeps the register pending.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (iss_hit && (iss_addr == r[AW-1:0]))
        busy_d[r] = 1'b1;
      else if ((wb0_hit && (wb0_addr == r[AW-1:0])) ||
               (wb1_hit && (wb1_addr == r[AW-1:0])))
        busy_d[r] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // The count is derived from next-state bits so it moves on the same edge.
  always_comb begin
    cnt_d = '0;
    for (int r = 1; r < NREG; r++)
      cnt_d = cnt_d + {{AW{1'b0}}, busy_d[r]};
  end

  // NOTE: every register is cleared on reset because software relies on a
  // zeroed file; this rules out mapping the array onto a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= '0;
      busy_q   <= '0;
      busy_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments; when both ports target the same
      // register the later wb1 assignment is the one that lands.
      if (wb0_hit)
        regs[wb0_addr] <= wb0_data;
      if (wb1_hit)
        regs[wb1_addr] <= wb1_data;
      busy_q   <= busy_d;
      busy_cnt <= cnt_d;
    end
  end

  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            busy;

    assign addr = rd_addr[p*AW +: AW];

    always_comb begin
      data = regs[addr];
      busy = busy_q[addr];
      if (addr == '0) begin
        data = '0;
        busy = 1'b0;
      end
`ifdef RF_BYPASS_EN
      // Forwarded data is final unless a new producer is issued this cycle.
      else if (wb1_hit && (wb1_addr == addr)) begin
        data = wb1_data;
        busy = (iss_en && (iss_addr == addr)) ? busy_q[addr] : 1'b0;
      end else if (wb0_hit && (wb0_addr == addr)) begin
        data = wb0_data;
        busy = (iss_en && (iss_addr == addr)) ? busy_q[addr] : 1'b0;
      end
`endif
    end

    assign rd_data[p*XLEN +: XLEN] = data;
    assign rd_busy[p]              = busy;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized traffic
// compared against a behavioural model (array of values, associative set of pending registers).
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRP  = 2;

  logic                clk;
  logic                reset;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data;
  logic [NRP-1:0]      rd_busy;
  logic                wb0_en, wb1_en, iss_en;
  logic [AW-1:0]       wb0_addr, wb1_addr, iss_addr;
  logic [XLEN-1:0]     wb0_data, wb1_data;
  logic [AW:0]         busy_cnt;

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wb0_en   (wb0_en),
    .wb0_addr (wb0_addr),
    .wb0_data (wb0_data),
    .wb1_en   (wb1_en),
    .wb1_addr (wb1_addr),
    .wb1_data (wb1_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: register values plus the set of registers awaiting write-back.
  logic [XLEN-1:0] mem [NREG];
  bit              pending [int];
  bit              model_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void exp_read(input logic [AW-1:0] a,
                                   output logic [XLEN-1:0] d, output logic b);
    int ai;
    ai = int'(a);
    d = mem[ai];
    b = pending.exists(ai);
    if (ai == 0) begin
      d = '0;
      b = 1'b0;
    end
`ifdef RF_BYPASS_EN
    else if ((wb1_en && wb1_addr == a) || (wb0_en && wb0_addr == a)) begin
      d = (wb1_en && wb1_addr == a) ? wb1_data : wb0_data;
      if (!(iss_en && iss_addr == a)) b = 1'b0;
    end
`endif
  endfunction

  function automatic void model_update();
    if (reset) begin
      for (int r = 0; r < NREG; r++) mem[r] = '0;
      pending.delete();
      model_valid = 1'b1;
      return;
    end
    if (wb0_en && wb0_addr != 0) mem[wb0_addr] = wb0_data;
    if (wb1_en && wb1_addr != 0) mem[wb1_addr] = wb1_data;
    if (wb0_en && wb0_addr != 0) pending.delete(int'(wb0_addr));
    if (wb1_en && wb1_addr != 0) pending.delete(int'(wb1_addr));
    if (iss_en && iss_addr != 0) pending[int'(iss_addr)] = 1'b1;
  endfunction

  // Called in the low phase with inputs applied; returns at the next negedge.
  task automatic cycle();
    logic [XLEN-1:0] ed;
    logic            eb;
    #1;
    if (model_valid) begin
      for (int p = 0; p < NRP; p++) begin
        exp_read(rd_addr[p*AW +: AW], ed, eb);
        check($sformatf("rd_data[%0d]", p), 64'(rd_data[p*XLEN +: XLEN]), 64'(ed));
        check($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(eb));
      end
    end
    @(posedge clk);
    #1;
    model_update();
    check("busy_cnt", 64'(busy_cnt), 64'(pending.num()));
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0;
    wb0_en = 1'b0; wb1_en = 1'b0; iss_en = 1'b0;
  endtask

  task automatic wb0(input int a, input logic [XLEN-1:0] d);
    wb0_en = 1'b1; wb0_addr = AW'(a); wb0_data = d;
  endtask

  task automatic wb1(input int a, input logic [XLEN-1:0] d);
    wb1_en = 1'b1; wb1_addr = AW'(a); wb1_data = d;
  endtask

  task automatic issue(input int a);
    iss_en = 1'b1; iss_addr = AW'(a);
  endtask

  // Directed read on port 0 with all write/issue inputs idle.
  task automatic peek(input string tag, input int a,
                      input logic [XLEN-1:0] d, input logic b);
    idle();
    rd_addr[0 +: AW] = AW'(a);
    #1;
    check({tag, "_data"}, 64'(rd_data[0 +: XLEN]), 64'(d));
    check({tag, "_busy"}, 64'(rd_busy[0]), 64'(b));
  endtask

  initial begin
    idle();
    reset = 1'b1;
    rd_addr = '0;
    wb0_addr = '0; wb1_addr = '0; iss_addr = '0;
    wb0_data = '0; wb1_data = '0;
    @(negedge clk);
    reset = 1'b1;
    cycle();
    cycle();

    // Preload registers and scoreboard, then reset with a write in flight.
    for (int r = 1; r < 8; r++) begin
      idle(); wb0(r, $urandom); issue(r + 8);
      rd_addr = {AW'(r - 1), AW'(r + 7)};
      cycle();
    end
    idle(); reset = 1'b1; wb0(5, 32'hDEADBEEF); issue(6);
    cycle();
    idle(); rd_addr = {AW'(6), AW'(5)};
    cycle();
    peek("rst_x5", 5, '0, 1'b0);
    check("rst_cnt", 64'(busy_cnt), 64'd0);

    // Writes to x0 are dropped; ordinary writes land.
    idle(); wb0(0, 32'h1234);       cycle();
    idle(); wb0(7, 32'hA5A5A5A5);   cycle();
    idle(); wb0(9, 32'h5555);       cycle();
    peek("x0", 0, '0, 1'b0);
    peek("x7", 7, 32'hA5A5A5A5, 1'b0);

    // Same-address collision: wb1 has priority.
    idle(); wb0(3, 32'h11); wb1(3, 32'h22); cycle();
    peek("x3", 3, 32'h22, 1'b0);

    // Issue vs write-back on the same register.
    idle(); issue(4); cycle();
    peek("iss_x4", 4, '0, 1'b1);
    check("iss_cnt", 64'(busy_cnt), 64'd1);
    idle(); wb0(4, 32'h99); issue(4); cycle();
    peek("wbiss_x4", 4, 32'h99, 1'b1);
    check("wbiss_cnt", 64'(busy_cnt), 64'd1);
    idle(); wb0(4, 32'h77); cycle();
    peek("wb_x4", 4, 32'h77, 1'b0);
    check("wb_cnt", 64'(busy_cnt), 64'd0);

    // Fill the scoreboard, then retire two in one cycle.
    for (int r = 1; r < NREG; r++) begin
      idle(); issue(r); rd_addr = {AW'(r), AW'(r - 1)};
      cycle();
    end
    check("full_cnt", 64'(busy_cnt), 64'(NREG - 1));
    idle(); issue(3); cycle();
    check("reissue_cnt", 64'(busy_cnt), 64'(NREG - 1));
    idle(); wb0(1, 32'h1); wb1(2, 32'h2); cycle();
    check("retire2_cnt", 64'(busy_cnt), 64'(NREG - 3));

    // Read of a busy register while its write-back is in flight.
    idle(); wb1(9, 32'hCAFE); rd_addr[0 +: AW] = AW'(9);
    #1;
`ifdef RF_BYPASS_EN
    check("byp_data", 64'(rd_data[0 +: XLEN]), 64'h0000CAFE);
    check("byp_busy", 64'(rd_busy[0]), 64'd0);
`else
    check("byp_data", 64'(rd_data[0 +: XLEN]), 64'h00005555);
    check("byp_busy", 64'(rd_busy[0]), 64'd1);
`endif
    cycle();
    peek("after_x9", 9, 32'hCAFE, 1'b0);

    // Randomized traffic; addresses are sometimes narrowed to force collisions.
    for (int i = 0; i < 3000; i++) begin
      int hi;
      hi = ($urandom_range(0, 3) == 0) ? 3 : NREG - 1;
      idle();
      reset    = ($urandom_range(0, 99) == 0);
      wb0_en   = $urandom_range(0, 1) == 1;
      wb1_en   = $urandom_range(0, 2) == 0;
      iss_en   = $urandom_range(0, 1) == 1;
      wb0_addr = AW'($urandom_range(0, hi));
      wb1_addr = AW'($urandom_range(0, hi));
      iss_addr = AW'($urandom_range(0, hi));
      wb0_data = $urandom;
      wb1_data = $urandom;
      for (int p = 0; p < NRP; p++) begin
        case ($urandom_range(0, 3))
          0: rd_addr[p*AW +: AW] = wb0_addr;
          1: rd_addr[p*AW +: AW] = wb1_addr;
          default: rd_addr[p*AW +: AW] = AW'($urandom_range(0, hi));
        endcase
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
